// File: rtl/alu_pkg.sv
// Shared opcode and state encodings for the sequential ALU.
package alu_pkg;

   typedef enum logic [3:0] {
      OP_AND  = 4'd0,
      OP_XOR  = 4'd1,
      OP_SLT  = 4'd2,
      OP_BNZ  = 4'd3,
      OP_ADDC = 4'd4,
      OP_ROR  = 4'd5,
      OP_LWA  = 4'd6,
      OP_SWA  = 4'd7,
      OP_SUB  = 4'd8,
      OP_SLL  = 4'd9,
      OP_MUL  = 4'd10,
      OP_DIV  = 4'd11
   } alu_op_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } alu_state_t;

   // Opcodes at or above this value are undefined and flagged as errors.
   localparam logic [3:0] OP_ILLEGAL_BASE = 4'd12;

endpackage

// File: rtl/alu_seq_mul_div_iter.sv
// Iterative unsigned multiplier / restoring divider sharing one 2W accumulator.
// The first iteration is folded into the start cycle, so W iterations end
// with a registered done pulse W-1 cycles after start.
module mul_div_iter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         start,
   input  logic         mode,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic         busy,
   output logic         done,
   output logic [W-1:0] lo,
   output logic [W-1:0] hi
);

   localparam int CW = $clog2(W);

   logic [2*W-1:0] acc;
   logic [W-1:0]   divisor;
   logic           div_mode;
   logic [CW-1:0]  cnt;

   // One iteration: shift-add for multiply (mode=0), restoring step for divide (mode=1).
   function automatic logic [2*W-1:0] step(input logic [2*W-1:0] cur,
                                           input logic [W-1:0]   m,
                                           input logic           is_div);
      logic [W:0]     part;
      logic [2*W-1:0] nxt;
      if (is_div) begin
         // Partial remainder after the left shift can need W+1 bits.
         part = cur[2*W-1:W-1] - {1'b0, m};
         if (cur[2*W-1:W-1] >= {1'b0, m})
            nxt = {part[W-1:0], cur[W-2:0], 1'b1};
         else
            nxt = {cur[2*W-2:0], 1'b0};
      end else begin
         part = {1'b0, cur[2*W-1:W]} + (cur[0] ? {1'b0, m} : {(W+1){1'b0}});
         nxt  = {part, cur[W-1:1]};
      end
      return nxt;
   endfunction

   // Datapath: load and first iteration on start, then one iteration per busy cycle.
   always_ff @(posedge clk) begin
      if (start) begin
         acc      <= step({{W{1'b0}}, a}, b, mode);
         divisor  <= b;
         div_mode <= mode;
      end else if (busy) begin
         acc <= step(acc, divisor, div_mode);
      end
   end

   // Control: count the remaining W-1 iterations and pulse done after the last.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         busy <= 1'b0;
         done <= 1'b0;
         cnt  <= '0;
      end else begin
         done <= 1'b0;
         if (start) begin
            busy <= 1'b1;
            cnt  <= CW'(W - 1);
         end else if (busy) begin
            cnt <= cnt - CW'(1);
            if (cnt == CW'(1)) begin
               busy <= 1'b0;
               done <= 1'b1;
            end
         end
      end
   end

   assign lo = acc[W-1:0];
   assign hi = acc[2*W-1:W];

endmodule

// File: rtl/alu_seq.sv
// Handshaked W-bit ALU: single-cycle logic/arith/branch ops plus iterative MUL/DIV.
// One request at a time; results are registered and held until out_ready.
module alu_seq
   import alu_pkg::*;
#(
   parameter int W  = 8,
   parameter int D  = 12,
   parameter int LW = $clog2(W)
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [3:0]    alu_cmd,
   input  logic [W-1:0]  inA,
   input  logic [W-1:0]  inB,
   input  logic [W-1:0]  reg0,
   input  logic [LW-1:0] amt,
   input  logic [D-1:0]  prog_ctr,
   input  logic          sc_i,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [W-1:0]  rslt,
   output logic [W-1:0]  rslt_hi,
   output logic [D-1:0]  pc_next,
   output logic          taken,
   output logic          sc_o,
   output logic          pari,
   output logic          zero,
   output logic          err
);

   alu_state_t    state;
   logic          accept;
   logic          iterate;
   logic [W-1:0]  c_rslt;
   logic [W-1:0]  c_hi;
   logic [D-1:0]  c_pc;
   logic          c_taken;
   logic          c_sc;
   logic          c_err;
   logic [D-1:0]  pc_inc;
   logic [W+1:0]  sum_addc;
   logic [W:0]    diff_sub;
   logic [LW:0]   lsh;
   logic [W-1:0]  rot;
   logic [D-1:0]  pc_lat;
   logic          sc_lat;
   logic          md_busy;
   logic          md_done;
   logic [W-1:0]  md_lo;
   logic [W-1:0]  md_hi;

   assign accept   = in_valid & in_ready;
   assign pc_inc   = prog_ctr + D'(1);
   assign sum_addc = {2'b00, inA} + {2'b00, reg0} + {2'b00, inB} + {{(W+1){1'b0}}, sc_i};
   assign diff_sub = {1'b0, inA} - {1'b0, inB} - {{W{1'b0}}, sc_i};
   // Left shift of W when amt is 0 clears that half, leaving inA unrotated.
   assign lsh      = (LW+1)'(W) - {1'b0, amt};
   assign rot      = (inA >> amt) | (inA << lsh);

   // Single-cycle result unit; MUL and nonzero-divisor DIV only raise iterate.
   always_comb begin
      c_rslt  = '0;
      c_hi    = '0;
      c_pc    = pc_inc;
      c_taken = 1'b0;
      c_sc    = sc_i;
      c_err   = 1'b0;
      iterate = 1'b0;
      case (alu_cmd)
         OP_AND:  c_rslt = inA & inB;
         OP_XOR:  c_rslt = inA ^ inB;
         OP_SLT:  c_rslt = {{(W-1){1'b0}}, inA < inB};
         OP_BNZ: begin
            c_taken = (inB != '0);
            if (inB != '0)
               c_pc = D'(inA);
         end
         OP_ADDC: begin
            c_rslt = sum_addc[W-1:0];
            c_sc   = |sum_addc[W+1:W];
         end
         OP_ROR:  c_rslt = rot;
         OP_LWA:  c_rslt = inA + inB;
         OP_SWA:  c_rslt = reg0 + inB;
         OP_SUB: begin
            c_rslt = diff_sub[W-1:0];
            c_sc   = diff_sub[W];
         end
         OP_SLL:  c_rslt = inA << amt;
         OP_MUL:  iterate = 1'b1;
         OP_DIV: begin
            if (inB == '0) begin
               c_rslt = '1;
               c_hi   = inA;
               c_err  = 1'b1;
            end else begin
               iterate = 1'b1;
            end
         end
         default: c_err = (alu_cmd >= OP_ILLEGAL_BASE);
      endcase
   end

   // Side-band values an iterative op needs when it completes, latched at accept.
   always_ff @(posedge clk) begin
      if (accept) begin
         pc_lat <= pc_inc;
         sc_lat <= sc_i;
      end
   end

   mul_div_iter #(.W(W)) u_mul_div (
      .clk     (clk),
      .reset_n (reset_n),
      .start   (accept & iterate),
      .mode    (alu_cmd == OP_DIV),
      .a       (inA),
      .b       (inB),
      .busy    (md_busy),
      .done    (md_done),
      .lo      (md_lo),
      .hi      (md_hi)
   );

   // Issue/complete FSM; all outputs registered and only updated at accept or completion.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         rslt      <= '0;
         rslt_hi   <= '0;
         pc_next   <= '0;
         taken     <= 1'b0;
         sc_o      <= 1'b0;
         pari      <= 1'b0;
         zero      <= 1'b0;
         err       <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  in_ready <= 1'b0;
                  if (iterate) begin
                     state <= BUSY;
                  end else begin
                     state     <= DONE;
                     out_valid <= 1'b1;
                     rslt      <= c_rslt;
                     rslt_hi   <= c_hi;
                     pc_next   <= c_pc;
                     taken     <= c_taken;
                     sc_o      <= c_sc;
                     pari      <= ^c_rslt;
                     zero      <= (c_rslt == '0);
                     err       <= c_err;
                  end
               end
            end
            BUSY: begin
               if (md_done) begin
                  state     <= DONE;
                  out_valid <= 1'b1;
                  rslt      <= md_lo;
                  rslt_hi   <= md_hi;
                  pc_next   <= pc_lat;
                  taken     <= 1'b0;
                  sc_o      <= sc_lat;
                  pari      <= ^md_lo;
                  zero      <= (md_lo == '0);
                  err       <= 1'b0;
               end else if (!md_busy) begin
                  // Iterator idle without finishing: recover rather than hang.
                  state    <= IDLE;
                  in_ready <= 1'b1;
               end
            end
            DONE: begin
               if (out_ready) begin
                  state     <= IDLE;
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
               end
            end
            default: begin
               state     <= IDLE;
               out_valid <= 1'b0;
               in_ready  <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq (W=8, D=12) with hand-computed directed vectors.
module tb_alu_seq;

   localparam int W  = 8;
   localparam int D  = 12;
   localparam int LW = $clog2(W);

   logic          clk = 1'b0;
   logic          reset_n;
   logic          in_valid;
   logic          in_ready;
   logic [3:0]    alu_cmd;
   logic [W-1:0]  inA, inB, reg0;
   logic [LW-1:0] amt;
   logic [D-1:0]  prog_ctr;
   logic          sc_i;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  rslt, rslt_hi;
   logic [D-1:0]  pc_next;
   logic          taken, sc_o, pari, zero, err;

   typedef struct {
      string        name;
      logic [W-1:0] r;
      logic [W-1:0] hi;
      logic [D-1:0] pc;
      logic         tk, sc, pa, ze, er;
      int           lat;
      int           acc;
   } exp_t;

   exp_t sb[$];
   int   n_chk  = 0;
   int   n_fail = 0;
   int   cyc    = 0;
   logic prev_v = 1'b0;

   alu_seq #(.W(W), .D(D)) dut (
      .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
      .alu_cmd(alu_cmd), .inA(inA), .inB(inB), .reg0(reg0), .amt(amt),
      .prog_ctr(prog_ctr), .sc_i(sc_i), .out_valid(out_valid), .out_ready(out_ready),
      .rslt(rslt), .rslt_hi(rslt_hi), .pc_next(pc_next), .taken(taken),
      .sc_o(sc_o), .pari(pari), .zero(zero), .err(err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic exp_t mk(input string n, input logic [7:0] r, input logic [7:0] hi,
                               input logic [11:0] pc, input logic tk, input logic sc,
                               input logic pa, input logic ze, input logic er, input int lat);
      exp_t e;
      e.name = n; e.r = r; e.hi = hi; e.pc = pc; e.tk = tk; e.sc = sc;
      e.pa = pa; e.ze = ze; e.er = er; e.lat = lat; e.acc = 0;
      return e;
   endfunction

   task automatic chk_reset(input string tag);
      chk({tag, "_in_ready"}, in_ready, 1);
      chk({tag, "_out_valid"}, out_valid, 0);
      chk({tag, "_rslt"}, rslt, 0);
      chk({tag, "_rslt_hi"}, rslt_hi, 0);
      chk({tag, "_pc_next"}, pc_next, 0);
      chk({tag, "_flags"}, {taken, sc_o, pari, zero, err}, 0);
   endtask

   // Monitor: each new out_valid presentation is matched against the oldest expectation.
   always @(negedge clk) begin
      exp_t e;
      if (reset_n && out_valid && !prev_v) begin
         if (sb.size() == 0) begin
            chk("unexpected_output", 1, 0);
         end else begin
            e = sb.pop_front();
            chk({e.name, "_rslt"}, rslt, e.r);
            chk({e.name, "_rslt_hi"}, rslt_hi, e.hi);
            chk({e.name, "_pc_next"}, pc_next, e.pc);
            chk({e.name, "_taken"}, taken, e.tk);
            chk({e.name, "_sc_o"}, sc_o, e.sc);
            chk({e.name, "_pari"}, pari, e.pa);
            chk({e.name, "_zero"}, zero, e.ze);
            chk({e.name, "_err"}, err, e.er);
            chk({e.name, "_latency"}, cyc - e.acc, e.lat);
         end
      end
      prev_v = reset_n && out_valid;
   end

   task automatic issue(input logic [3:0] cmd, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] r0, input logic [2:0] am, input logic [11:0] pc,
                        input logic sci, input exp_t e);
      int guard = 0;
      @(negedge clk);
      alu_cmd = cmd; inA = a; inB = b; reg0 = r0; amt = am; prog_ctr = pc; sc_i = sci;
      in_valid = 1'b1;
      while (!in_ready && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      if (!in_ready) begin
         chk({e.name, "_issue_timeout"}, 0, 1);
         in_valid = 1'b0;
         return;
      end
      e.acc = cyc;
      sb.push_back(e);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      // Scramble operands so results must come from the values latched at accept.
      inA = ~a; inB = ~b; reg0 = ~r0; prog_ctr = ~pc; sc_i = ~sci;
   endtask

   task automatic drain();
      int guard = 0;
      while ((sb.size() != 0 || !in_ready) && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      chk("drain_queue", sb.size(), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int bad;
      reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      alu_cmd = '0; inA = '0; inB = '0; reg0 = '0; amt = '0; prog_ctr = '0; sc_i = 1'b0;
      repeat (2) @(negedge clk);
      chk_reset("reset");
      reset_n = 1'b1;

      issue(4'd4,  8'hF0, 8'h0F, 8'h01, 3'd0, 12'h100, 1'b1, mk("addc",     8'h01, 8'h00, 12'h101, 0, 1, 1, 0, 0, 1));
      issue(4'd4,  8'hFF, 8'hFF, 8'hFF, 3'd0, 12'h100, 1'b1, mk("addc_max", 8'hFE, 8'h00, 12'h101, 0, 1, 1, 0, 0, 1));
      issue(4'd3,  8'h2A, 8'h00, 8'h00, 3'd0, 12'hFFF, 1'b0, mk("bnz_nt",   8'h00, 8'h00, 12'h000, 0, 0, 0, 1, 0, 1));
      issue(4'd3,  8'h2A, 8'h01, 8'h00, 3'd0, 12'hFFF, 1'b0, mk("bnz_t",    8'h00, 8'h00, 12'h02A, 1, 0, 0, 1, 0, 1));

      // MUL with requests offered during BUSY, which must be ignored.
      issue(4'd10, 8'hFF, 8'hFF, 8'h00, 3'd0, 12'h100, 1'b0, mk("mul_ff",   8'h01, 8'hFE, 12'h101, 0, 0, 1, 0, 0, 9));
      bad = 0;
      alu_cmd = 4'd0; in_valid = 1'b1;
      repeat (8) begin
         @(negedge clk);
         if (in_ready) bad++;
      end
      in_valid = 1'b0;
      chk("mul_busy_in_ready_low", bad, 0);

      issue(4'd11, 8'hC8, 8'h07, 8'h00, 3'd0, 12'h100, 1'b0, mk("div",      8'h1C, 8'h04, 12'h101, 0, 0, 1, 0, 0, 9));
      issue(4'd11, 8'hC8, 8'h00, 8'h00, 3'd0, 12'h100, 1'b0, mk("div0",     8'hFF, 8'hC8, 12'h101, 0, 0, 0, 0, 1, 1));
      issue(4'd5,  8'hA5, 8'h00, 8'h00, 3'd3, 12'h100, 1'b0, mk("ror3",     8'hB4, 8'h00, 12'h101, 0, 0, 0, 0, 0, 1));
      issue(4'd5,  8'hA5, 8'h00, 8'h00, 3'd0, 12'h100, 1'b0, mk("ror0",     8'hA5, 8'h00, 12'h101, 0, 0, 0, 0, 0, 1));
      issue(4'd8,  8'h05, 8'h07, 8'h00, 3'd0, 12'h100, 1'b0, mk("sub",      8'hFE, 8'h00, 12'h101, 0, 1, 1, 0, 0, 1));
      issue(4'd8,  8'h05, 8'h05, 8'h00, 3'd0, 12'h100, 1'b1, mk("sub_bin",  8'hFF, 8'h00, 12'h101, 0, 1, 0, 0, 0, 1));
      issue(4'd13, 8'h12, 8'h34, 8'h00, 3'd0, 12'h100, 1'b1, mk("ill13",    8'h00, 8'h00, 12'h101, 0, 1, 0, 1, 1, 1));
      issue(4'd0,  8'hC3, 8'h5A, 8'h00, 3'd0, 12'h200, 1'b0, mk("and",      8'h42, 8'h00, 12'h201, 0, 0, 0, 0, 0, 1));
      issue(4'd1,  8'hC3, 8'h5A, 8'h00, 3'd0, 12'h200, 1'b1, mk("xor",      8'h99, 8'h00, 12'h201, 0, 1, 0, 0, 0, 1));
      issue(4'd2,  8'h03, 8'h04, 8'h00, 3'd0, 12'h200, 1'b0, mk("slt_t",    8'h01, 8'h00, 12'h201, 0, 0, 1, 0, 0, 1));
      issue(4'd2,  8'h04, 8'h03, 8'h00, 3'd0, 12'h200, 1'b0, mk("slt_f",    8'h00, 8'h00, 12'h201, 0, 0, 0, 1, 0, 1));
      issue(4'd6,  8'hF0, 8'h20, 8'h00, 3'd0, 12'h200, 1'b0, mk("lwa",      8'h10, 8'h00, 12'h201, 0, 0, 1, 0, 0, 1));
      issue(4'd7,  8'h00, 8'h90, 8'h80, 3'd0, 12'h200, 1'b0, mk("swa",      8'h10, 8'h00, 12'h201, 0, 0, 1, 0, 0, 1));
      issue(4'd9,  8'h81, 8'h00, 8'h00, 3'd1, 12'h200, 1'b0, mk("sll",      8'h02, 8'h00, 12'h201, 0, 0, 1, 0, 0, 1));
      issue(4'd10, 8'h0D, 8'h0B, 8'h00, 3'd0, 12'h200, 1'b1, mk("mul_small",8'h8F, 8'h00, 12'h201, 0, 1, 1, 0, 0, 9));
      drain();

      // Back-pressure: result held while out_ready is low; new requests ignored.
      out_ready = 1'b0;
      issue(4'd0,  8'hFF, 8'h0F, 8'h00, 3'd0, 12'h300, 1'b0, mk("hold",     8'h0F, 8'h00, 12'h301, 0, 0, 0, 0, 0, 1));
      alu_cmd = 4'd1; inA = 8'h11; inB = 8'h22; in_valid = 1'b1;
      repeat (5) begin
         @(negedge clk);
         chk("hold_rslt", rslt, 8'h0F);
         chk("hold_out_valid", out_valid, 1);
         chk("hold_in_ready", in_ready, 0);
      end
      in_valid = 1'b0;
      @(negedge clk);
      out_ready = 1'b1;
      drain();

      // Reset in the middle of a multiply: op aborted, nothing emerges afterwards.
      issue(4'd10, 8'hFF, 8'hFF, 8'h00, 3'd0, 12'h100, 1'b0, mk("mul_abort", 8'h01, 8'hFE, 12'h101, 0, 0, 1, 0, 0, 9));
      repeat (4) @(negedge clk);
      #2;
      reset_n = 1'b0;
      #1;
      sb.delete();
      chk_reset("midreset");
      @(negedge clk);
      reset_n = 1'b1;
      repeat (12) @(negedge clk);
      chk("post_abort_in_ready", in_ready, 1);
      chk("post_abort_out_valid", out_valid, 0);

      issue(4'd1,  8'h0F, 8'hF0, 8'h00, 3'd0, 12'h7FF, 1'b0, mk("after_rst", 8'hFF, 8'h00, 12'h800, 0, 0, 0, 0, 0, 1));
      drain();
      repeat (2) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
